// File: rtl/online_fir_sym_pipe.sv
// Symmetric online FIR on borrow-save samples: pre-add, shift-add multiply, pipelined adder tree.
// Optional ONLINE_FIR_COEF_LOAD_EN adds run-time loadable coefficient registers.
module online_fir_sym_pipe #(
    parameter int STAGE  = 8,
    parameter int NTAPS  = 8,
    parameter int GROWTH = 14,
    parameter int CW     = 8,
    parameter logic [CW*(NTAPS/2)-1:0] COEFS = {8'd203, 8'd122, 8'd41, 8'd6},
    parameter int PIPE   = 2
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              enable,
    input  logic                              clr,
    input  logic                              din_valid,
    input  logic [2*STAGE-1:0]                din_x,
`ifdef ONLINE_FIR_COEF_LOAD_EN
    input  logic                              coef_we,
    input  logic [((NTAPS/2 > 1) ? $clog2(NTAPS/2) : 1)-1:0] coef_addr,
    input  logic [CW-1:0]                     coef_data,
`endif
    output logic                              dout_valid,
    output logic [2*(STAGE+GROWTH)-1:0]       data_out
);

    localparam int WL   = 2 * STAGE;
    localparam int H    = NTAPS / 2;
    localparam int DO   = STAGE + GROWTH;
    localparam int SW   = DO + 1;
    localparam int XW   = STAGE + 1;
    localparam int NLVL = (H > 1) ? $clog2(H) : 0;
    localparam int CNTW = $clog2(NTAPS + 1);

    typedef logic signed [SW-1:0] acc_t;
    typedef logic signed [XW-1:0] smp_t;
    typedef acc_t [H-1:0]         vec_t;
    typedef logic [2*DO-1:0]      bs_t;

    function automatic int coef_sum();
        int s = 0;
        for (int k = 0; k < H; k++) s += int'(COEFS[k*CW +: CW]);
        return s;
    endfunction

    // Tree levels completed once stage p has registered; the output stage finishes the rest.
    function automatic int cum_lv(int p);
        return ((p + 1) * NLVL) / (PIPE + 1);
    endfunction

    function automatic smp_t to_bin(logic [WL-1:0] x);
        logic [STAGE-1:0] pos, neg;
        for (int i = 0; i < STAGE; i++) begin
            pos[i] = x[2*i+1];
            neg[i] = x[2*i];
        end
        return $signed({1'b0, pos}) - $signed({1'b0, neg});
    endfunction

    function automatic acc_t cmul(acc_t s, logic [CW-1:0] c);
        acc_t acc = '0;
        for (int b = 0; b < CW; b++)
            if (c[b]) acc = acc + (s <<< b);
        return acc;
    endfunction

    function automatic vec_t reduce_lv(vec_t v, int n);
        vec_t w, t;
        w = v;
        for (int l = 0; l < n; l++) begin
            t = '0;
            for (int j = 0; j < H; j++) begin
                if (2*j + 1 < H)  t[j] = w[2*j] + w[2*j+1];
                else if (2*j < H) t[j] = w[2*j];
            end
            w = t;
        end
        return w;
    endfunction

    function automatic acc_t sum_lv(vec_t v, int n);
        vec_t w;
        w = reduce_lv(v, n);
        return w[0];
    endfunction

    function automatic bs_t to_bs(acc_t y);
        bs_t  r;
        acc_t mag;
        r   = '0;
        mag = y[SW-1] ? -y : y;
        for (int i = 0; i < DO; i++) begin
            r[2*i+1] = ~y[SW-1] & mag[i];
            r[2*i]   =  y[SW-1] & mag[i];
        end
        return r;
    endfunction

    localparam int CSUM = coef_sum();

    if (NTAPS % 2 != 0 || NTAPS < 2 || NTAPS > 16) begin : g_bad_ntaps
        $error("online_fir_sym_pipe: NTAPS must be even and within 2..16");
    end
    if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
        $error("online_fir_sym_pipe: PIPE must be within 0..4");
    end
    if (GROWTH < $clog2(2 * CSUM) + 1) begin : g_bad_growth
        $error("online_fir_sym_pipe: GROWTH too small for an exact result");
    end

    // Control: a sample is taken when enable && din_valid && !clr. dout_valid is a one-cycle
    // tag per qualifying sample and is frozen (not cleared) while enable is low.
    logic             accept;
    smp_t             tap [NTAPS];
    logic [CNTW-1:0]  fill_cnt;
    logic             tag0_q;

    assign accept = enable & din_valid & ~clr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < NTAPS; k++) tap[k] <= '0;
            fill_cnt <= '0;
            tag0_q   <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < NTAPS; k++) tap[k] <= '0;
            fill_cnt <= '0;
            tag0_q   <= 1'b0;
        end else if (enable) begin
            tag0_q <= accept && (fill_cnt >= CNTW'(NTAPS - 1));
            if (accept) begin
                tap[0] <= to_bin(din_x);
                for (int k = 1; k < NTAPS; k++) tap[k] <= tap[k-1];
                if (fill_cnt != CNTW'(NTAPS)) fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    logic [CW-1:0] coef_use [H];

`ifdef ONLINE_FIR_COEF_LOAD_EN
    logic [CW-1:0] coef_r [H];

    // coef_use snapshots the written set on each accept so a write only reaches later samples.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < H; k++) begin
                coef_r[k]   <= COEFS[k*CW +: CW];
                coef_use[k] <= COEFS[k*CW +: CW];
            end
        end else begin
            if (accept)
                for (int k = 0; k < H; k++) coef_use[k] <= coef_r[k];
            if (coef_we && int'(coef_addr) < H)
                coef_r[coef_addr] <= coef_data;
        end
    end
`else
    for (genvar k = 0; k < H; k++) begin : g_coef
        assign coef_use[k] = COEFS[k*CW +: CW];
    end
`endif

    vec_t prod;

    always_comb begin
        prod = '0;
        for (int k = 0; k < H; k++)
            prod[k] = cmul(acc_t'(tap[k]) + acc_t'(tap[NTAPS-1-k]), coef_use[k]);
    end

    for (genvar p = 0; p < PIPE; p++) begin : g_stage
        localparam int LV = cum_lv(p) - ((p == 0) ? 0 : cum_lv(p - 1));
        vec_t d_in, q;
        logic t_in, tq;

        if (p == 0) begin : g_head
            assign d_in = prod;
            assign t_in = tag0_q;
        end else begin : g_link
            assign d_in = g_stage[p-1].q;
            assign t_in = g_stage[p-1].tq;
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                q  <= '0;
                tq <= 1'b0;
            end else if (clr) begin
                q  <= '0;
                tq <= 1'b0;
            end else if (enable) begin
                q  <= reduce_lv(d_in, LV);
                tq <= t_in;
            end
        end
    end

    localparam int LV_OUT = NLVL - ((PIPE == 0) ? 0 : cum_lv(PIPE - 1));

    vec_t last_d;
    logic last_t;
    acc_t y_sum;

    if (PIPE == 0) begin : g_nopipe
        assign last_d = prod;
        assign last_t = tag0_q;
    end else begin : g_tail
        assign last_d = g_stage[PIPE-1].q;
        assign last_t = g_stage[PIPE-1].tq;
    end

    assign y_sum = sum_lv(last_d, LV_OUT);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_out   <= '0;
            dout_valid <= 1'b0;
        end else if (clr) begin
            data_out   <= '0;
            dout_valid <= 1'b0;
        end else if (enable) begin
            data_out   <= to_bs(y_sum);
            dout_valid <= last_t;
        end
    end

endmodule

// File: tb/tb_online_fir_sym_pipe.sv
// Bench for online_fir_sym_pipe: impulse table, step/stall/clear/reset sequences and a random run
// against a queue-based reference model.
module tb_online_fir_sym_pipe;

    localparam int STAGE = 8;
    localparam int NTAPS = 8;
    localparam int PIPE  = 2;
    localparam int WL    = 2 * STAGE;
    localparam int DO    = STAGE + 14;
    localparam int WO    = 2 * DO;
`ifdef ONLINE_FIR_COEF_LOAD_EN
    localparam bit COEF_LOAD = 1'b1;
`else
    localparam bit COEF_LOAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst, enable, clr, din_valid;
    logic [WL-1:0] din_x;
    logic          dout_valid;
    logic [WO-1:0] data_out;
`ifdef ONLINE_FIR_COEF_LOAD_EN
    logic          coef_we;
    logic [1:0]    coef_addr;
    logic [7:0]    coef_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    online_fir_sym_pipe dut (
        .clk       (clk),
        .nrst      (nrst),
        .enable    (enable),
        .clr       (clr),
        .din_valid (din_valid),
        .din_x     (din_x),
`ifdef ONLINE_FIR_COEF_LOAD_EN
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
`endif
        .dout_valid(dout_valid),
        .data_out  (data_out)
    );

    // ---------------- reference model ----------------
    typedef struct { longint y; bit v; } ent_t;

    longint   hist[$];
    int       acc_cnt;
    ent_t     fifo[$];
    ent_t     exp_out;
    longint   cf_w[4];
    longint   cf_a[4];
    longint   exp_q[$];

    function automatic longint dec_in(logic [WL-1:0] x);
        longint v = 0;
        for (int i = 0; i < STAGE; i++)
            v += (longint'(x[2*i+1]) - longint'(x[2*i])) <<< i;
        return v;
    endfunction

    function automatic longint dec_out(logic [WO-1:0] d);
        longint v = 0;
        for (int i = 0; i < DO; i++)
            v += (longint'(d[2*i+1]) - longint'(d[2*i])) <<< i;
        return v;
    endfunction

    function automatic longint tap_y();
        longint s = 0;
        for (int k = 0; k < NTAPS; k++)
            if (k < hist.size())
                s += hist[k] * cf_a[(k < NTAPS/2) ? k : NTAPS-1-k];
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        acc_cnt = 0;
        fifo.delete();
        for (int i = 0; i < PIPE + 1; i++) fifo.push_back('{0, 1'b0});
        exp_out = '{0, 1'b0};
        cf_w = '{6, 41, 122, 203};
        cf_a = cf_w;
    endtask

    task automatic model_edge(input bit en, input bit cl, input bit dv, input longint xv,
                              input bit we, input int wa, input int wd);
        bit tag;
        if (cl) begin
            hist.delete();
            acc_cnt = 0;
            fifo.delete();
            for (int i = 0; i < PIPE + 1; i++) fifo.push_back('{0, 1'b0});
            exp_out = '{0, 1'b0};
        end else if (en) begin
            tag = 1'b0;
            if (dv) begin
                cf_a = cf_w;
                hist.push_front(xv);
                if (hist.size() > NTAPS) void'(hist.pop_back());
                if (acc_cnt < NTAPS) acc_cnt++;
                tag = (acc_cnt == NTAPS);
            end
            fifo.push_back('{tap_y(), tag});
            exp_out = fifo.pop_front();
        end
        if (COEF_LOAD && we && wa >= 0 && wa < 4) cf_w[wa] = longint'(wd);
    endtask

    // ---------------- driver / checker ----------------
    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input bit en, input bit cl, input bit dv, input logic [WL-1:0] din,
                       input bit we = 1'b0, input int wa = 0, input int wd = 0);
        enable    = en;
        clr       = cl;
        din_valid = dv;
        din_x     = din;
`ifdef ONLINE_FIR_COEF_LOAD_EN
        coef_we   = we;
        coef_addr = 2'(wa);
        coef_data = 8'(wd);
`endif
        @(posedge clk);
        model_edge(en, cl, dv, dec_in(din), we, wa, wd);
        #1;
        chk("model_v", longint'(dout_valid), longint'(exp_out.v));
        chk("model_y", dec_out(data_out), exp_out.y);
    endtask

    task automatic do_reset();
        nrst      = 1'b0;
        enable    = 1'b0;
        clr       = 1'b0;
        din_valid = 1'b0;
        din_x     = '0;
`ifdef ONLINE_FIR_COEF_LOAD_EN
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
`endif
        @(posedge clk);
        #1;
        chk("reset_v", longint'(dout_valid), 0);
        chk("reset_y", dec_out(data_out), 0);
        model_reset();
        nrst = 1'b1;
    endtask

    typedef struct { logic [WL-1:0] din; bit dv; longint y; bit v; } row_t;

    task automatic run_impulse(input longint c0, input bit with_reset);
        row_t   tbl[19];
        longint yimp[19] = '{0, 0, 0, 6, 41, 122, 203, 203, 122, 41, 6, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 19; i++) begin
            tbl[i].din = (i == 0) ? 16'h0002 : 16'h0000;
            tbl[i].dv  = (i < 16);
            tbl[i].y   = (i == 3 || i == 10) ? c0 : yimp[i];
            tbl[i].v   = (i >= 10);
        end
        if (with_reset) do_reset();
        for (int i = 0; i < 19; i++) begin
            cyc(1'b1, 1'b0, tbl[i].dv, tbl[i].din);
            chk("imp_y", dec_out(data_out), tbl[i].y);
            chk("imp_v", longint'(dout_valid), longint'(tbl[i].v));
        end
    endtask

    task automatic run_step(input logic [WL-1:0] din, input longint yv, input string name);
        int nv = 0;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 1'b0, i < 12, din);
            if (dout_valid) begin
                nv++;
                chk(name, dec_out(data_out), yv);
            end
        end
        chk({name, "_pulses"}, nv, 5);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [WL-1:0] smp[14];
        int idx, ngot, nexp, first, nv;
        bit en, dv;

        do_reset();
        run_impulse(6, 1'b0);

        run_step(16'h0002, 744, "step_pos");
        run_step(16'h5555, -189720, "step_neg");
        run_step(16'h0009, 744, "step_redund");

        // stall: reference stream from an unstalled run, then the same samples with gaps
        for (int i = 0; i < 14; i++) smp[i] = 16'($urandom);
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cyc(1'b1, 1'b0, i < 14, (i < 14) ? smp[i] : 16'h0000);
            if (exp_out.v) exp_q.push_back(exp_out.y);
        end
        nexp = exp_q.size();
        do_reset();
        idx  = 0;
        ngot = 0;
        for (int c = 0; c < 41; c++) begin
            en = !(c >= 15 && c <= 19);
            dv = !(c >= 6 && c <= 10) && (idx < 14);
            cyc(en, 1'b0, dv, dv ? smp[idx] : 16'h0000);
            if (en && dv) idx++;
            if (en && dout_valid) begin
                ngot++;
                if (exp_q.size() > 0) chk("stall_y", dec_out(data_out), exp_q.pop_front());
            end
        end
        chk("stall_pulses", ngot, nexp);
        exp_q.delete();

        // clear after 10 samples
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 16'($urandom));
        cyc(1'b1, 1'b1, 1'b1, 16'($urandom));
        chk("clr_y", dec_out(data_out), 0);
        chk("clr_v", longint'(dout_valid), 0);
        first = -1;
        nv    = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, 1'b0, i < 8, 16'($urandom));
            if (dout_valid) begin
                nv++;
                if (first < 0) first = i;
            end
        end
        chk("clr_first_valid", first, 10);
        chk("clr_pulses", nv, 1);

        // asynchronous reset pulse between edges with the pipeline full
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 16'h0002 | 16'($urandom_range(0, 255)));
        #1 nrst = 1'b0;
        #2;
        chk("arst_y", dec_out(data_out), 0);
        chk("arst_v", longint'(dout_valid), 0);
        #1 nrst = 1'b1;
        model_reset();
        run_impulse(6, 1'b0);

`ifdef ONLINE_FIR_COEF_LOAD_EN
        // coefficient write mid-stream, then impulse
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 16'($urandom));
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 16'h0000);
        run_impulse(1, 1'b0);
`endif

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 3) != 0, 16'($urandom),
                $urandom_range(0, 15) == 0, $urandom_range(0, 3), $urandom_range(0, 255));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
